// File: rtl/uart_rx_ctrl_param_if.sv
// UART receive controller bundle: serial line plus frame mode in, parallel word and status out.
interface uart_rx_ctrl_param_if #(
    parameter int unsigned DATA_W = 8
);
    logic              RX_IN;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic              STOP2;
    logic [DATA_W-1:0] P_DATA;
    logic              data_valid;
    logic              par_err;
    logic              stp_err;
    logic              strt_glitch;
    logic              busy;

    // Receiver side
    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, STOP2,
        output P_DATA, data_valid, par_err, stp_err, strt_glitch, busy
    );

    // Line driver / data consumer side
    modport master (
        output RX_IN, PAR_EN, PAR_TYP, STOP2,
        input  P_DATA, data_valid, par_err, stp_err, strt_glitch, busy
    );
endinterface

// File: rtl/uart_rx_ctrl_param.sv
// Parametrised UART receiver: start detect, 3-point majority sampling, LSB-first shifting,
// optional odd/even parity, 1 or 2 stop bits, per-frame mode latching and framing checks.
module uart_rx_ctrl_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned OVERSAMP = 8
) (
    input logic                  CLK,
    input logic                  RST,
    uart_rx_ctrl_param_if.slave  rx_if
);
    localparam int unsigned EDGE_W = $clog2(OVERSAMP);
    localparam int unsigned BIT_W  = $clog2(DATA_W + 4);
    localparam int unsigned MID    = OVERSAMP / 2;

    localparam logic [EDGE_W-1:0] SMP_A     = EDGE_W'(MID - 1);
    localparam logic [EDGE_W-1:0] SMP_B     = EDGE_W'(MID);
    localparam logic [EDGE_W-1:0] SMP_C     = EDGE_W'(MID + 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(OVERSAMP - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W);
    // With OVERSAMP=4 the third sample point coincides with the bit end cycle
    localparam bit                LATE_SMP  = (MID + 1 == OVERSAMP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]          smp_q, smp_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                par_en_q, par_en_d;
    logic                par_typ_q, par_typ_d;
    logic                stop2_q, stop2_d;
    logic                stp_bad_q, stp_bad_d;
    logic [DATA_W-1:0]   pdata_q, pdata_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                serr_q, serr_d;
    logic                glitch_q, glitch_d;
    logic                busy_q, busy_d;

    logic                bit_end_c;
    logic                smp_late_c;
    logic                sample_c;
    logic                stop_bad_c;
    logic [BIT_W-1:0]    stop_last_c;

    // Bit-end strobe, majority vote and framing helpers
    always_comb begin
        bit_end_c   = (edge_cnt_q == EDGE_LAST);
        smp_late_c  = LATE_SMP ? rx_if.RX_IN : smp_q[2];
        sample_c    = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_late_c) | (smp_q[1] & smp_late_c);
        stop_bad_c  = stp_bad_q | ~sample_c;
        stop_last_c = BIT_W'(DATA_W + 1) + BIT_W'(par_en_q) + BIT_W'(stop2_q);
    end

    // Next-state, counters, datapath and output pulses
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        smp_d      = smp_q;
        shreg_d    = shreg_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop2_d    = stop2_q;
        stp_bad_d  = stp_bad_q;
        pdata_d    = pdata_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;
        glitch_d   = 1'b0;

        if (state_q != S_IDLE) begin
            edge_cnt_d = bit_end_c ? '0 : edge_cnt_q + EDGE_W'(1);
            bit_cnt_d  = bit_end_c ? bit_cnt_q + BIT_W'(1) : bit_cnt_q;
            if (edge_cnt_q == SMP_A) smp_d[0] = rx_if.RX_IN;
            if (edge_cnt_q == SMP_B) smp_d[1] = rx_if.RX_IN;
            if (edge_cnt_q == SMP_C) smp_d[2] = rx_if.RX_IN;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_if.RX_IN) begin
                    state_d    = S_START;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    stp_bad_d  = 1'b0;
                    par_en_d   = rx_if.PAR_EN;
                    par_typ_d  = rx_if.PAR_TYP;
                    stop2_d    = rx_if.STOP2;
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    if (sample_c) begin
                        glitch_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    shreg_d = {sample_c, shreg_q[DATA_W-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end_c) begin
                    if (sample_c != (^shreg_q ^ par_typ_q)) begin
                        perr_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (bit_end_c) begin
                    if (bit_cnt_q != stop_last_c) begin
                        stp_bad_d = stop_bad_c;
                    end else if (stop_bad_c) begin
                        serr_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        valid_d = 1'b1;
                        pdata_d = shreg_q;
                        if (!rx_if.RX_IN) begin
                            // Next start bit already on the line: chain without an idle cycle
                            state_d    = S_START;
                            edge_cnt_d = '0;
                            bit_cnt_d  = '0;
                            stp_bad_d  = 1'b0;
                            par_en_d   = rx_if.PAR_EN;
                            par_typ_d  = rx_if.PAR_TYP;
                            stop2_d    = rx_if.STOP2;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            smp_q      <= '0;
            shreg_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stp_bad_q  <= 1'b0;
            pdata_q    <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            glitch_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            smp_q      <= smp_d;
            shreg_q    <= shreg_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            stp_bad_q  <= stp_bad_d;
            pdata_q    <= pdata_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            glitch_q   <= glitch_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_if.P_DATA      = pdata_q;
    assign rx_if.data_valid  = valid_q;
    assign rx_if.par_err     = perr_q;
    assign rx_if.stp_err     = serr_q;
    assign rx_if.strt_glitch = glitch_q;
    assign rx_if.busy        = busy_q;
endmodule

// File: tb/tb_uart_rx_ctrl_param.sv
// Scoreboard bench for uart_rx_ctrl_param: an 8-bit and a 5-bit receiver, OVERSAMP=8.
module tb_uart_rx_ctrl_param;
    localparam int unsigned OVS = 8;

    localparam logic [3:0] K_VALID  = 4'b0001;
    localparam logic [3:0] K_PERR   = 4'b0010;
    localparam logic [3:0] K_SERR   = 4'b0100;
    localparam logic [3:0] K_GLITCH = 4'b1000;

    typedef struct {
        logic [3:0]  kind;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q8[$];
    exp_t q5[$];
    logic [31:0] pdm [2];

    uart_rx_ctrl_param_if #(.DATA_W(8)) if8 ();
    uart_rx_ctrl_param_if #(.DATA_W(5)) if5 ();

    uart_rx_ctrl_param #(.DATA_W(8), .OVERSAMP(OVS)) u_dut8 (
        .CLK   (clk),
        .RST   (rst),
        .rx_if (if8)
    );

    uart_rx_ctrl_param #(.DATA_W(5), .OVERSAMP(OVS)) u_dut5 (
        .CLK   (clk),
        .RST   (rst),
        .rx_if (if5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic mon(input int sel, input logic [3:0] k, input logic [31:0] pd, input logic busy);
        exp_t e;
        string p;
        p = (sel == 0) ? "w8_" : "w5_";
        if (k != 4'b0000) begin
            if ((sel == 0 && q8.size() == 0) || (sel == 1 && q5.size() == 0)) begin
                check_eq({p, "unexpected_pulse"}, 32'(k), 32'd0);
            end else begin
                e = (sel == 0) ? q8.pop_front() : q5.pop_front();
                check_eq({p, "pulse_kind"}, 32'(k), 32'(e.kind));
                check_eq({p, "pulse_cycle"}, 32'(cyc), 32'(e.cyc));
                check_eq({p, "p_data"}, pd, e.data);
                if (e.kind != K_VALID) check_eq({p, "busy_after_err"}, 32'(busy), 32'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, {if8.strt_glitch, if8.stp_err, if8.par_err, if8.data_valid}, 32'(if8.P_DATA), if8.busy);
            mon(1, {if5.strt_glitch, if5.stp_err, if5.par_err, if5.data_valid}, 32'(if5.P_DATA), if5.busy);
        end
    end

    task automatic set_line(input int sel, input logic b);
        if (sel == 0) if8.RX_IN = b;
        else          if5.RX_IN = b;
    endtask

    task automatic set_mode(input logic pe, input logic pt, input logic s2);
        if8.PAR_EN = pe; if8.PAR_TYP = pt; if8.STOP2 = s2;
        if5.PAR_EN = pe; if5.PAR_TYP = pt; if5.STOP2 = s2;
    endtask

    task automatic push_exp(input int sel, input exp_t e);
        if (sel == 0) q8.push_back(e);
        else          q5.push_back(e);
    endtask

    // Drive one frame (called on a negedge); mode inputs are flipped after the start bit
    task automatic send_frame(input int sel, input logic [8:0] data, input int nd,
                              input logic pe, input logic pt, input logic s2,
                              input logic pflip, input logic [1:0] stp);
        logic [15:0] v;
        int          n;
        logic        p;
        exp_t        e;
        p = pt;
        v = '0;
        for (int i = 0; i < nd; i++) begin
            p        = p ^ data[i];
            v[1 + i] = data[i];
        end
        n = 1 + nd;
        if (pe) begin v[n] = p ^ pflip; n++; end
        v[n] = stp[0]; n++;
        if (s2) begin v[n] = stp[1]; n++; end

        if (pe && pflip) begin
            e = '{K_PERR, pdm[sel], cyc + 1 + (2 + nd) * int'(OVS)};
        end else if (!stp[0] || (s2 && !stp[1])) begin
            e = '{K_SERR, pdm[sel], cyc + 1 + n * int'(OVS)};
        end else begin
            pdm[sel] = 32'(data);
            e = '{K_VALID, pdm[sel], cyc + 1 + n * int'(OVS)};
        end
        push_exp(sel, e);

        set_mode(pe, pt, s2);
        for (int k = 0; k < n; k++) begin
            set_line(sel, v[k]);
            repeat (OVS) @(negedge clk);
            if (k == 0) set_mode(~pe, ~pt, ~s2);
        end
        set_line(sel, 1'b1);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_w8_out"}, 32'({if8.P_DATA, if8.data_valid, if8.par_err, if8.stp_err,
                                         if8.strt_glitch, if8.busy}), 32'd0);
        check_eq({tag, "_w5_out"}, 32'({if5.P_DATA, if5.data_valid, if5.par_err, if5.stp_err,
                                         if5.strt_glitch, if5.busy}), 32'd0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        if8.RX_IN = 1'b1;
        if5.RX_IN = 1'b1;
        set_mode(1'b0, 1'b0, 1'b0);
        pdm[0] = '0;
        pdm[1] = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0xA5, even parity correct, 1 stop
        send_frame(0, 9'h0A5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
        repeat (20) @(negedge clk);

        // 0xA5, odd parity expected but 0 sent
        send_frame(0, 9'h0A5, 8, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
        repeat (20) @(negedge clk);

        // Short low pulse: start glitch
        e = '{K_GLITCH, pdm[0], cyc + 1 + int'(OVS)};
        q8.push_back(e);
        set_line(0, 1'b0);
        repeat (2) @(negedge clk);
        set_line(0, 1'b1);
        repeat (20) @(negedge clk);

        // Two stop bits, second one low
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
        repeat (20) @(negedge clk);

        // Back-to-back frames, no idle gap
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        repeat (20) @(negedge clk);
        send_frame(1, 9'h015, 5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        send_frame(1, 9'h00A, 5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        repeat (20) @(negedge clk);

        // 5-bit, odd parity, two stop bits, all good; then first stop bit low
        send_frame(1, 9'h00B, 5, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
        send_frame(1, 9'h01E, 5, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10);
        repeat (20) @(negedge clk);

        // Reset mid-frame aborts silently
        set_mode(1'b0, 1'b0, 1'b0);
        set_line(0, 1'b0);
        repeat (OVS) @(negedge clk);
        set_line(0, 1'b1);
        repeat (21) @(negedge clk);
        check_eq("busy_mid_frame", 32'(if8.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_quiet("reset_mid_frame");
        pdm[0] = '0;
        pdm[1] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);

        for (int i = 0; i < 300 && (q8.size() + q5.size()) != 0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        check_eq("sb_empty_w8", 32'(q8.size()), 32'd0);
        check_eq("sb_empty_w5", 32'(q5.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
